mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative 32-bit multiply/divide unit in the EX stage of the MIPS datapath. It takes the same two operand buses as the 32-bit adder and executes MULT, MULTU, DIV and DIVU over 32 iteration cycles. Results go to the architectural HI/LO registers, which also accept MTHI/MTLO writes. The pipeline controller uses `busy` to stall MFHI/MFLO and any new multiply/divide.

## Interface
Parameters:
- none. Width is fixed at 32 and iteration count at 32.

Ports:
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  launch the operation selected by `op` on `a`, `b`.
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  operand rs (multiplicand / dividend).
- `b`  in  32  operand rt (multiplier / divisor).
- `we_hi`  in  1  MTHI write strobe.
- `we_lo`  in  1  MTLO write strobe.
- `wdata`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse when HI/LO take a new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE and CALC.
- IDLE -> CALC:
  - on a rising edge with `start`=1 while in IDLE.
  - `op`, `a` and `b` are latched into internal registers. Later input changes have no effect.
  - For signed ops, operands are converted to magnitudes and the result signs are recorded.
- CALC:
  - runs a 6-bit iteration counter from 0 to 31, one shift-add (multiply) or shift-subtract restoring step (divide) per cycle.
  - CALC -> IDLE on the edge where the counter reaches 31. That same edge writes the sign-corrected result into `hi`/`lo` and sets `done` for one cycle.
- Multiply results:
  - {hi,lo} = full 64-bit product.
  - MULT treats operands as two's complement; MULTU treats them as unsigned.
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; signed remainder takes the sign of the dividend.
- Divide special cases:
  - Divide by zero (b=0), DIV or DIVU: lo=32'hFFFFFFFF, hi=a.
  - DIV 32'h80000000 / 32'hFFFFFFFF: lo=32'h80000000, hi=0.
- `hi`/`lo` keep their old values for the whole of CALC. Only the final edge updates them.
- MTHI/MTLO:
  - In IDLE, `we_hi`/`we_lo` load `wdata` into hi/lo on the edge.
  - If both strobes are set, both registers load `wdata`.
  - In CALC, the strobes are ignored.
- Simultaneous events:
  - `start` together with `we_hi`/`we_lo` in IDLE: `start` wins and the writes are dropped.
  - `start` while busy is ignored; the running operation is unaffected.
- Reset (`rst_n`=0, any time, including mid-CALC):
  - Takes effect immediately, not waiting for a clock edge. Aborts any operation and returns to IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0; counter and internal operand registers are cleared.

## Timing
- Reset values: busy 0, done 0, hi 32'h0, lo 32'h0.
- `busy` is registered. It is 1 from the edge that accepts `start` (E0) until edge E32, i.e. high for exactly 32 cycles.
- Edge E32:
  - drives `busy` to 0, `done` to 1 and `hi`/`lo` to the result.
  - `done` returns to 0 at E33.
- Back-to-back operation: a `start` sampled at E32 is not accepted, because the unit is still busy in the cycle before. The earliest accepted restart is E33, so operation-to-operation spacing is 33 cycles.
- Outputs depend only on registers; there is no combinational path from inputs to `busy`/`done`/`hi`/`lo`.
- Special-case results (divide by zero, signed overflow) keep the full 32-cycle latency.

## Test plan
- MULT a=2, b=32'hFFFFFFFC (-4) -> after 32 busy cycles: done pulse, hi=32'hFFFFFFFF, lo=32'hFFFFFFF8.
- MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001. Then DIV a=32'hFFFFFFF9 (-7), b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- Divide special cases:
  - DIVU a=7, b=0 -> lo=32'hFFFFFFFF, hi=7.
  - DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
- `start` at cycle 10 of a running DIVU 100/7 with different operands, plus `we_hi` during CALC -> both ignored; result lo=14, hi=2; hi/lo unchanged until done.
- MTHI wdata=32'h12345678 and MTLO wdata=32'hCAFEBABE in IDLE -> hi/lo load next edge. Same cycle as `start` -> writes dropped, operation launches.
- Assert `rst_n`=0 mid-cycle during CALC iteration 15 -> busy, done, hi, lo go to 0 without waiting for an edge. A fresh MULTU 3x5 after release -> lo=15, hi=0, busy for 32 cycles.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One shift-add or restoring shift-subtract step per cycle, 32 steps per operation.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic [31:0] m_q, m_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] wrk_q, wrk_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        op_signed_s;
  logic [32:0] mul_sum_s;
  logic [32:0] div_shift_s;
  logic [33:0] div_diff_s;
  logic        div_ge_s;
  logic [31:0] step_acc_s;
  logic [31:0] step_wrk_s;
  logic [63:0] prod_s;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

  assign op_signed_s = ~op[0];

  // Multiply: acc:wrk holds the partial product, wrk starts as the multiplier.
  assign mul_sum_s   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, m_q} : 33'd0);
  // Divide: acc is the running remainder, wrk shifts dividend out and quotient in.
  assign div_shift_s = {acc_q, wrk_q[31]};
  assign div_diff_s  = {1'b0, div_shift_s} - {2'b00, m_q};
  assign div_ge_s    = ~div_diff_s[33];

  assign step_acc_s  = is_div_q ? (div_ge_s ? div_diff_s[31:0] : div_shift_s[31:0])
                                : mul_sum_s[32:1];
  assign step_wrk_s  = is_div_q ? {wrk_q[30:0], div_ge_s}
                                : {mul_sum_s[0], wrk_q[31:1]};
  assign prod_s      = {step_acc_s, step_wrk_s};

  // Next-state, datapath load/step and HI/LO update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    m_d       = m_q;
    acc_d     = acc_q;
    wrk_d     = wrk_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CALC;
          busy_d    = 1'b1;
          cnt_d     = 6'd0;
          is_div_d  = op[1];
          acc_d     = 32'd0;
          m_d       = op[1] ? abs32(b, op_signed_s) : abs32(a, op_signed_s);
          wrk_d     = op[1] ? abs32(a, op_signed_s) : abs32(b, op_signed_s);
          // A zero divisor must leave the all-ones quotient unnegated.
          neg_res_d = op_signed_s & (a[31] ^ b[31]) & (~op[1] | (b != 32'd0));
          neg_rem_d = op_signed_s & op[1] & a[31];
        end else begin
          if (we_hi) begin
            hi_d = wdata;
          end else begin
            hi_d = hi_q;
          end
          if (we_lo) begin
            lo_d = wdata;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      CALC: begin
        acc_d = step_acc_s;
        wrk_d = step_wrk_s;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = 6'd0;
          if (is_div_q) begin
            lo_d = neg_res_q ? neg32(step_wrk_s) : step_wrk_s;
            hi_d = neg_rem_q ? neg32(step_acc_s) : step_acc_s;
          end else begin
            {hi_d, lo_d} = neg_res_q ? neg64(prod_s) : prod_s;
          end
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = 6'd0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      is_div_q  <= 1'b0;
      m_q       <= 32'd0;
      acc_q     <= 32'd0;
      wrk_q     <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      wrk_q     <= wrk_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus queues expected {hi,lo},
// a negedge monitor pops and compares on every done pulse.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        we_hi = 1'b0;
  logic        we_lo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic [63:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  mul_div_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .we_hi(we_hi), .we_lo(we_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done actual=%h%h required=none", hi, lo);
      end else begin
        check("result", {hi, lo}, exp_q.pop_front());
      end
    end
  end

  // Launch one operation and follow it to completion; inj >= 0 injects a
  // second start plus an MTHI write that many cycles into CALC.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] eh, input logic [31:0] el,
                        input logic [31:0] ph, input logic [31:0] pl, input int inj);
    int cyc;
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; we_hi = 1'b0; we_lo = 1'b0;
    exp_q.push_back({eh, el});
    check({nm, "_busy_start"}, {63'd0, busy}, 64'd1);
    check({nm, "_hilo_hold_e0"}, {hi, lo}, {ph, pl});
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == inj) begin
        start = 1'b1; op = 2'b00; a = 32'd55; b = 32'd66;
        we_hi = 1'b1; wdata = 32'hAAAA5555;
      end else if (cyc == inj + 1) begin
        start = 1'b0; we_hi = 1'b0;
      end
      if (cyc == 31) check({nm, "_hilo_hold_e31"}, {hi, lo}, {ph, pl});
    end
    check({nm, "_latency"}, 64'(cyc), 64'd32);
    check({nm, "_done_pulse"}, {63'd0, done}, 64'd1);
    @(posedge clk); #1;
    check({nm, "_done_clear"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mult_2_m4",  2'b00, 32'd2, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'd0, 32'd0, -1);
    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,
           32'hFFFFFFFF, 32'hFFFFFFF8, -1);
    run_op("div_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD,
           32'hFFFFFFFE, 32'h00000001, -1);
    run_op("divu_by0",   2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'hFFFFFFFD, -1);
    run_op("div_m7_by0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF,
           32'd7, 32'hFFFFFFFF, -1);
    run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000,
           32'hFFFFFFF9, 32'hFFFFFFFF, -1);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 32'd0, 32'h80000000, 10);

    we_hi = 1'b1; wdata = 32'h12345678;
    @(posedge clk); #1;
    we_hi = 1'b0;
    check("mthi", {hi, lo}, {32'h12345678, 32'd14});
    we_lo = 1'b1; wdata = 32'hCAFEBABE;
    @(posedge clk); #1;
    we_lo = 1'b0;
    check("mtlo", {hi, lo}, {32'h12345678, 32'hCAFEBABE});
    we_hi = 1'b1; we_lo = 1'b1; wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    we_hi = 1'b0; we_lo = 1'b0;
    check("mthi_mtlo_both", {hi, lo}, {32'h0BADF00D, 32'h0BADF00D});

    we_hi = 1'b1; we_lo = 1'b1; wdata = 32'hDEADBEEF;
    run_op("start_beats_mt", 2'b01, 32'd6, 32'd7, 32'd0, 32'd42,
           32'h0BADF00D, 32'h0BADF00D, -1);

    op = 2'b00; a = 32'd1234; b = 32'd5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    check("abort_busy_before", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_done", {63'd0, done}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("multu_3_5", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 32'd0, 32'd0, -1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
